fpu_sgnj_pipe: RTL and testbench
================================

// Module: fpu_sgnj_pipe
// PURPOSE
//  Two-stage elastic pipeline around the combinational sign-injection unit (FSGNJ/FSGNJN/FSGNJX).
//  Accepts RISC-V funct3 plus operands from the FPU issue logic and decodes funct3 into the one-hot op.
//  Drives the sign-injection unit from its stage-1 registers and captures that unit's result in stage 2.
//  Returns the result to writeback over a valid/ready handshake.
// PARAMETERS
//  Std   31  MSB index of an operand (width Std+1)
//  Exp   7   exponent MSB index (exponent width Exp+1); carried through to the sign-injection unit only
//  Man   22  mantissa MSB index; carried through to the sign-injection unit only
//  TAG_W 5   width of the destination tag (rd) passed alongside each operation
// PORTS
//  clk         in   1        clock; all state updates on its rising edge
//  rst_l       in   1        synchronous active-low reset
//  flush       in   1        synchronous kill of all in-flight operations
//  in_valid    in   1        upstream offers an operation
//  in_ready    out  1        block accepts the operation this cycle
//  in_funct3   in   3        000 sgnj, 001 sgnjn, 010 sgnjx, others illegal
//  in_a        in   Std+1    operand A (source of exponent/mantissa, sign for sgnjx)
//  in_b        in   Std+1    operand B (sign source)
//  in_tag      in   TAG_W    destination tag
//  sgnj_op     out  3        one-hot op to sign-injection unit: bit0 sgnj, bit1 sgnjn, bit2 sgnjx
//  sgnj_a      out  Std+1    stage-1 operand A to sign-injection unit
//  sgnj_b      out  Std+1    stage-1 operand B to sign-injection unit
//  sgnj_res    in   Std+1    combinational result from sign-injection unit
//  out_valid   out  1        stage-2 result available
//  out_ready   in   1        downstream consumes the result
//  out_data    out  Std+1    result
//  out_tag     out  TAG_W    tag of the result
//  out_illegal out  1        result came from an illegal funct3
//  busy        out  1        s1_valid | s2_valid
// BEHAVIOUR
//  Reset: rst_l=0 at a rising edge clears s1_valid, s2_valid and all data/tag/op registers to 0.
//   Consequently out_valid=0, out_data=0, out_tag=0, out_illegal=0, sgnj_op=0, sgnj_a=0, sgnj_b=0 and busy=0.
//   Reset mid-operation discards every in-flight operation. No output is produced for them.
//  Handshake:
//   s2_free  = ~s2_valid | out_ready
//   s1_adv   = s1_valid & s2_free
//   in_ready = ~flush & (~s1_valid | s1_adv)   (combinational, no dependence on in_valid)
//   An operation is accepted when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
//  Stage 1, on accept: loads funct3-decoded one-hot op, illegal bit, in_a, in_b and in_tag.
//   Illegal funct3 (011..111) gives sgnj_op=000 and illegal=1.
//   The stage-1 registers drive sgnj_op, sgnj_a and sgnj_b directly.
//  Stage 2, on s1_adv: captures sgnj_res (forced to 0 if the illegal bit is set), the tag and the illegal bit.
//  Valid bits:
//   s1_valid next = accept | (s1_valid & ~s1_adv)
//   s2_valid next = s1_adv | (s2_valid & ~out_ready)
//  Latency: 2 cycles from accept to out_valid. Throughput: 1 op/cycle when out_ready is held high.
//  Full: s1 and s2 valid with out_ready=0 gives in_ready=0. All stage registers hold.
//   out_data, out_tag and out_illegal stay stable while out_valid & ~out_ready.
//  Simultaneous accept and s1_adv: s1 reloads with the new op in the same edge that s2 captures the old one.
//  flush=1: s1_valid and s2_valid are cleared at the edge and in_ready=0. No accept occurs that cycle.
//   Data registers keep their values (don't-care); out_valid=0 on the following cycle.
//  Precedence: rst_l=0 over flush; flush over accept/advance.
// TESTING
//  1 Reset with in_valid=1 -> out_valid=0, in_ready=1, sgnj_op=0 and busy=0 on the first cycle after reset.
//  2 A=32'h3F800000, B=32'hC0000000, out_ready=1, funct3=000/001/010 on consecutive cycles
//    -> out_data 32'hBF800000 / 32'h3F800000 / 32'hBF800000 on cycles 2, 3, 4 after the first accept.
//    Tags preserved in order.
//  3 funct3=011, A=32'h40490FDB, tag=7 -> 2 cycles later out_valid=1, out_data=0, out_illegal=1, out_tag=7.
//  4 out_ready=0 while issuing 3 ops -> in_ready=0 after 2 accepts. out_data is stable.
//    Raise out_ready -> the 3rd op is accepted in the same cycle the 1st drains. No loss or duplication.
//  5 flush=1 while both stages are full and in_valid=1 -> next cycle out_valid=0, busy=0.
//    The offered op is not accepted; it is accepted on the first cycle with flush=0.
//  6 rst_l=0 for one cycle with both stages full -> out_valid=0 and all outputs 0 afterwards.
//    A subsequent op completes with 2-cycle latency.

Source files
------------

// File: rtl/fpu_sgnj_pipe.sv
// Two-stage elastic pipeline wrapped around the combinational FSGNJ/FSGNJN/FSGNJX unit.
// Stage 1 holds the decoded request and drives the unit; stage 2 holds the result for writeback.
module fpu_sgnj_pipe #(
    parameter int Std   = 31,
    parameter int Exp   = 7,
    parameter int Man   = 22,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [Std:0]     in_a,
    input  logic [Std:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [2:0]       sgnj_op,
    output logic [Std:0]     sgnj_a,
    output logic [Std:0]     sgnj_b,
    input  logic [Std:0]     sgnj_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Std:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    typedef struct packed {
        logic [2:0]       op;
        logic             illegal;
        logic [Std:0]     a;
        logic [Std:0]     b;
        logic [TAG_W-1:0] tag;
    } s1_req_t;

    typedef struct packed {
        logic [Std:0]     data;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } s2_rsp_t;

    s1_req_t s1;
    s2_rsp_t s2;
    logic    s1_valid, s2_valid;
    logic    s2_free, s1_adv, accept;
    logic [2:0] dec_op;
    logic    dec_ill;

    // Exponent/mantissa split is the sign-injection unit's business, not ours.
    logic unused_params;
    assign unused_params = ((Exp + Man + 1) == Std);

    assign s2_free  = ~s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_free;
    assign in_ready = ~flush & (~s1_valid | s1_adv);
    assign accept   = in_valid & in_ready;

    always_comb begin
        dec_op  = 3'b000;
        dec_ill = 1'b0;
        case (in_funct3)
            3'b000:  dec_op  = 3'b001;
            3'b001:  dec_op  = 3'b010;
            3'b010:  dec_op  = 3'b100;
            default: dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
        end else if (flush) begin
            // Data registers are left as-is; only the valid bits matter after a kill.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept | (s1_valid & ~s1_adv);
            s2_valid <= s1_adv | (s2_valid & ~out_ready);
            if (accept) begin
                s1.op      <= dec_op;
                s1.illegal <= dec_ill;
                s1.a       <= in_a;
                s1.b       <= in_b;
                s1.tag     <= in_tag;
            end
            if (s1_adv) begin
                s2.data    <= s1.illegal ? '0 : sgnj_res;
                s2.tag     <= s1.tag;
                s2.illegal <= s1.illegal;
            end
        end
    end

    assign sgnj_op     = s1.op;
    assign sgnj_a      = s1.a;
    assign sgnj_b      = s1.b;
    assign out_valid   = s2_valid;
    assign out_data    = s2.data;
    assign out_tag     = s2.tag;
    assign out_illegal = s2.illegal;
    assign busy        = s1_valid | s2_valid;

endmodule

// File: tb/tb_fpu_sgnj_pipe.sv
// Bench for fpu_sgnj_pipe: hand vector table, directed corner sequences and a random run
// checked against a queue-based in-flight model of the pipeline.
module tb_fpu_sgnj_pipe;

    logic        clk = 1'b0;
    logic        rst_l, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [2:0]  in_funct3, sgnj_op;
    logic [31:0] in_a, in_b, sgnj_a, sgnj_b, sgnj_res, out_data;
    logic [4:0]  in_tag, out_tag;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [2:0]  op;
        logic [31:0] data;
        logic        ill;
    } vec_t;

    always #5 clk = ~clk;

    fpu_sgnj_pipe #(.Std(31), .Exp(7), .Man(22), .TAG_W(5)) dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .sgnj_op(sgnj_op), .sgnj_a(sgnj_a), .sgnj_b(sgnj_b), .sgnj_res(sgnj_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
    );

    // Stand-in sign-injection unit; a zero op yields junk so forcing to 0 is visible.
    always_comb begin
        sgnj_res = 32'hDEADBEEF;
        if (sgnj_op == 3'b001) sgnj_res = {sgnj_b[31], sgnj_a[30:0]};
        else if (sgnj_op == 3'b010) sgnj_res = {~sgnj_b[31], sgnj_a[30:0]};
        else if (sgnj_op == 3'b100) sgnj_res = {sgnj_a[31] ^ sgnj_b[31], sgnj_a[30:0]};
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic s;
        case (f3)
            3'd0:    s = b[31];
            3'd1:    s = ~b[31];
            3'd2:    s = a[31] ^ b[31];
            default: return 32'h0;
        endcase
        return {s, a[30:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, update model, pass posedge.
    task automatic tick(input logic iv, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic ordy, input logic fl, output logic acc);
        logic m_rdy, m_ov;
        exp_t e;
        @(negedge clk);
        in_valid = iv; in_funct3 = f3; in_a = a; in_b = b; in_tag = tag;
        out_ready = ordy; flush = fl;
        #1;
        m_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        // Two in flight means both stages are full; only a draining output frees a slot.
        m_rdy = !fl && ((q.size() < 2) || ordy);
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, q.size() > 0);
        if (m_ov) begin
            e = q[0];
            chk(ordy ? "out_data" : "hold_data", out_data, e.data);
            chk(ordy ? "out_tag" : "hold_tag", out_tag, e.tag);
            chk(ordy ? "out_illegal" : "hold_illegal", out_illegal, e.ill);
            if (ordy) void'(q.pop_front());
        end
        if (fl) q.delete();
        acc = iv && m_rdy;
        if (acc) q.push_back('{ref_res(f3, a, b), tag, (f3 > 3'd2), cyc});
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy, input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, ordy, 1'b0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0; in_valid = 1'b1; in_funct3 = 3'd0; in_a = 32'h3F800000; in_b = 32'hC0000000;
        in_tag = 5'd9; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        cyc++;
        q.delete();
        @(negedge clk);
        rst_l = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sgnj_op", sgnj_op, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        chk("rst_sgnj_a", sgnj_a, 32'h0);
        chk("rst_sgnj_b", sgnj_b, 32'h0);
        @(posedge clk);
        cyc++;
    endtask

    vec_t tv[10];

    initial begin
        logic acc;
        logic [2:0] f3;

        tv[0] = '{3'd0, 32'h3F800000, 32'hC0000000, 5'd1,  3'b001, 32'hBF800000, 1'b0};
        tv[1] = '{3'd1, 32'h3F800000, 32'hC0000000, 5'd2,  3'b010, 32'h3F800000, 1'b0};
        tv[2] = '{3'd2, 32'h3F800000, 32'hC0000000, 5'd3,  3'b100, 32'hBF800000, 1'b0};
        tv[3] = '{3'd3, 32'h40490FDB, 32'h00000000, 5'd7,  3'b000, 32'h00000000, 1'b1};
        tv[4] = '{3'd0, 32'hBF800000, 32'h40000000, 5'd4,  3'b001, 32'h3F800000, 1'b0};
        tv[5] = '{3'd1, 32'hBF800000, 32'h40000000, 5'd5,  3'b010, 32'hBF800000, 1'b0};
        tv[6] = '{3'd2, 32'hBF800000, 32'hC0000000, 5'd6,  3'b100, 32'h3F800000, 1'b0};
        tv[7] = '{3'd7, 32'h12345678, 32'h80000000, 5'd31, 3'b000, 32'h00000000, 1'b1};
        tv[8] = '{3'd2, 32'h7FC00000, 32'h80000000, 5'd8,  3'b100, 32'hFFC00000, 1'b0};
        tv[9] = '{3'd1, 32'h00000000, 32'h00000000, 5'd0,  3'b010, 32'h80000000, 1'b0};

        rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; in_funct3 = 3'd0;
        in_a = 32'h0; in_b = 32'h0; in_tag = 5'd0; out_ready = 1'b0;

        // Reset with in_valid asserted
        do_reset();

        // Table: one op at a time, hand-computed results
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, tv[i].f3, tv[i].a, tv[i].b, tv[i].tag, 1'b1, 1'b0, acc);
            #1;
            chk("tbl_sgnj_op", sgnj_op, tv[i].op);
            chk("tbl_sgnj_a", sgnj_a, tv[i].a);
            idle(1'b1, 1);
            #1;
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_data", out_data, tv[i].data);
            chk("tbl_tag", out_tag, tv[i].tag);
            chk("tbl_illegal", out_illegal, tv[i].ill);
            idle(1'b1, 1);
        end

        // Back-to-back sgnj/sgnjn/sgnjx, full throughput
        for (int i = 0; i < 3; i++)
            tick(1'b1, 3'(i), 32'h3F800000, 32'hC0000000, 5'(10 + i), 1'b1, 1'b0, acc);
        idle(1'b1, 3);

        // Stall: two accepts fill the pipe, third waits, then enters as the first drains
        tick(1'b1, 3'd0, 32'h11111111, 32'h80000000, 5'd21, 1'b0, 1'b0, acc);
        chk("stall_acc1", acc, 1'b1);
        tick(1'b1, 3'd1, 32'h22222222, 32'h80000000, 5'd22, 1'b0, 1'b0, acc);
        chk("stall_acc2", acc, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 3'd2, 32'hB3333333, 32'h80000000, 5'd23, 1'b0, 1'b0, acc);
            chk("stall_acc3_blocked", acc, 1'b0);
        end
        tick(1'b1, 3'd2, 32'hB3333333, 32'h80000000, 5'd23, 1'b1, 1'b0, acc);
        chk("stall_acc3_on_drain", acc, 1'b1);
        idle(1'b1, 4);

        // Flush with both stages full and an op on offer
        tick(1'b1, 3'd0, 32'h40000000, 32'h80000000, 5'd1, 1'b0, 1'b0, acc);
        tick(1'b1, 3'd1, 32'h40400000, 32'h80000000, 5'd2, 1'b0, 1'b0, acc);
        tick(1'b1, 3'd2, 32'hC0800000, 32'h80000000, 5'd3, 1'b0, 1'b1, acc);
        chk("flush_no_accept", acc, 1'b0);
        tick(1'b1, 3'd2, 32'hC0800000, 32'h80000000, 5'd3, 1'b0, 1'b0, acc);
        chk("flush_accept_after", acc, 1'b1);
        idle(1'b1, 3);

        // Reset mid-flight with both stages full, then a fresh op
        tick(1'b1, 3'd0, 32'h3F000000, 32'h80000000, 5'd4, 1'b0, 1'b0, acc);
        tick(1'b1, 3'd1, 32'h3E000000, 32'h00000000, 5'd5, 1'b0, 1'b0, acc);
        do_reset();
        tick(1'b1, 3'd0, 32'h3F800000, 32'hC0000000, 5'd6, 1'b1, 1'b0, acc);
        idle(1'b1, 3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            tick($urandom_range(0, 9) < 7, f3, $urandom, $urandom, 5'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, acc);
        end
        idle(1'b1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
